// File: rtl/io_pkg.sv
// Types and constants shared by the Mano serial I/O ports (transmitter now, receiver later).
package io_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam logic SERIAL_IDLE = 1'b1;

endpackage

// File: rtl/RippleCarryIncrementer.sv
// Plain ripple-carry +1 incrementer built from a chain of half adders.
module RippleCarryIncrementer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value_in,
  output logic [WIDTH-1:0] sum_out
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  // The carry out of the top bit is never needed, so the chain stops one stage short.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign sum_out[i] = value_in[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = value_in[i] & carry[i];
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Bit-period timer: pulses tick_out on the last cycle of every CLOCKS_PER_BIT-cycle period
// while enabled, and restarts from zero whenever enable_in is low.
module baud_tick_generator #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_in,
  output logic tick_out
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  RippleCarryIncrementer #(.WIDTH(CNT_W)) u_incrementer (
    .value_in (count),
    .sum_out  (count_inc)
  );

  assign tick_out = enable_in && (count == LAST_COUNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable_in || tick_out) begin
      count <= '0;
    end else begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/output_port_transmitter.sv
// Device side of the Mano output port: holds OUTR and FGO and shifts each accepted
// character out as a start bit, LSB-first data bits and a stop bit.
module output_port_transmitter
  import io_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [BITS-1:0] data_in,
  input  logic            load_in,
  output logic            fgo_out,
  output logic            tx_out,
  output logic            overrun_out
);

  localparam int IDX_W = $clog2(BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

  tx_state_t        state;
  tx_state_t        next_state;
  logic [BITS-1:0]  outr;
  logic [BITS-1:0]  outr_next;
  logic [IDX_W-1:0] bit_index;
  logic [IDX_W-1:0] bit_index_next;
  logic [IDX_W-1:0] bit_index_inc;
  logic             fgo_next;
  logic             tx_next;
  logic             overrun_next;
  logic             following_bit;
  logic             tick;

  baud_tick_generator #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_baud (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable_in (state != TX_IDLE),
    .tick_out  (tick)
  );

  assign bit_index_inc = bit_index + IDX_W'(1);

  // tx_out is registered, so the bit that goes out after the current one is selected here.
  always_comb begin
    following_bit = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      if (bit_index_inc == IDX_W'(i)) following_bit = outr[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= TX_IDLE;
      outr        <= '0;
      bit_index   <= '0;
      fgo_out     <= 1'b1;
      tx_out      <= SERIAL_IDLE;
      overrun_out <= 1'b0;
    end else begin
      state       <= next_state;
      outr        <= outr_next;
      bit_index   <= bit_index_next;
      fgo_out     <= fgo_next;
      tx_out      <= tx_next;
      overrun_out <= overrun_next;
    end
  end

  // Loads are qualified by the registered FGO; any load while busy is dropped and flagged.
  always_comb begin
    next_state     = state;
    outr_next      = outr;
    bit_index_next = bit_index;
    fgo_next       = fgo_out;
    tx_next        = tx_out;
    overrun_next   = overrun_out | (load_in & ~fgo_out);
    case (state)
      TX_IDLE: begin
        if (load_in && fgo_out) begin
          outr_next  = data_in;
          fgo_next   = 1'b0;
          tx_next    = 1'b0;
          next_state = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          bit_index_next = '0;
          tx_next        = outr[0];
          next_state     = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_index == LAST_IDX) begin
            tx_next    = SERIAL_IDLE;
            next_state = TX_STOP;
          end else begin
            bit_index_next = bit_index_inc;
            tx_next        = following_bit;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          fgo_next   = 1'b1;
          tx_next    = SERIAL_IDLE;
          next_state = TX_IDLE;
        end
      end
      default: begin
        next_state = TX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_output_port_transmitter.sv
// Randomized and directed bench for output_port_transmitter; two instances (4 and 1 clocks
// per bit) are compared every cycle against a frame-position reference model.
module tb_output_port_transmitter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       load0 = 1'b0;
  logic       load1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       fgo0, tx0, ovr0;
  logic       fgo1, tx1, ovr1;

  int error_count = 0;
  int check_count = 0;

  // Reference model: a frame is the 10-bit word {stop, data, start} and the expected line
  // level is simply the frame bit at (cycles since acceptance) / clocks-per-bit.
  bit         m_act   [2];
  int         m_pos   [2];
  logic [9:0] m_frame [2];
  bit         m_ovr   [2];
  int         m_cpb   [2];

  always #5 clock = ~clock;

  output_port_transmitter #(.BITS(8), .CLOCKS_PER_BIT(4)) dut_cpb4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data0),
    .load_in     (load0),
    .fgo_out     (fgo0),
    .tx_out      (tx0),
    .overrun_out (ovr0)
  );

  output_port_transmitter #(.BITS(8), .CLOCKS_PER_BIT(1)) dut_cpb1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data1),
    .load_in     (load1),
    .fgo_out     (fgo1),
    .tx_out      (tx1),
    .overrun_out (ovr1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_pos[d] = 0;
      m_ovr[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d, input bit load, input logic [7:0] data);
    bit was_ready;
    was_ready = !m_act[d];
    if (m_act[d]) begin
      m_pos[d]++;
      if (m_pos[d] == 10 * m_cpb[d]) m_act[d] = 1'b0;
    end
    if (load) begin
      if (was_ready) begin
        m_act[d]   = 1'b1;
        m_pos[d]   = 0;
        m_frame[d] = {1'b1, data, 1'b0};
      end else begin
        m_ovr[d] = 1'b1;
      end
    end
  endtask

  function automatic logic exp_tx(input int d);
    int bit_no;
    bit_no = m_pos[d] / m_cpb[d];
    return m_act[d] ? m_frame[d][bit_no] : 1'b1;
  endfunction

  task automatic check_all();
    checkOutput("tx_cpb4",  32'(tx0),  32'(exp_tx(0)));
    checkOutput("fgo_cpb4", 32'(fgo0), 32'(!m_act[0]));
    checkOutput("ovr_cpb4", 32'(ovr0), 32'(m_ovr[0]));
    checkOutput("tx_cpb1",  32'(tx1),  32'(exp_tx(1)));
    checkOutput("fgo_cpb1", 32'(fgo1), 32'(!m_act[1]));
    checkOutput("ovr_cpb1", 32'(ovr1), 32'(m_ovr[1]));
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, check 1 time unit later.
  task automatic applyStimulus(input bit l0, input logic [7:0] d0,
                               input bit l1, input logic [7:0] d1);
    load0 = l0;
    data0 = d0;
    load1 = l1;
    data1 = d1;
    @(posedge clock);
    model_edge(0, l0, d0);
    model_edge(1, l1, d1);
    #1;
    check_all();
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 8'($urandom));
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    m_cpb[0] = 4;
    m_cpb[1] = 1;
    model_reset();

    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset_fgo", 32'(fgo0), 32'd1);
    checkOutput("reset_tx",  32'(tx0),  32'd1);
    checkOutput("reset_ovr", 32'(ovr0), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] single frame");
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'h55);
    idle(45);

    $display("[TB] overrun while busy");
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    idle(11);
    applyStimulus(1'b1, 8'h3C, 1'b1, 8'h3C);
    idle(40);

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'hA5);
    idle(18);
    async_reset();
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'hFF);
    idle(42);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h01);
    for (int i = 0; i < 100 && m_act[0]; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h80, 1'b1, 8'h80);
    idle(42);

    $display("[TB] load in final stop cycle");
    applyStimulus(1'b1, 8'h6B, 1'b0, 8'h00);
    for (int i = 0; i < 100 && m_pos[0] < 39; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00);
    idle(5);

    $display("[TB] randomized traffic");
    async_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      applyStimulus($urandom_range(0, 14) == 0, 8'($urandom),
                    $urandom_range(0, 5) == 0, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
